sync_fifo_lvl: RTL and testbench
================================

Name: sync_fifo_lvl

Overview:
- Single-clock, parametrised FIFO. It is the synchronous successor to the dual-clock FIFO family.
- Used where producer and consumer share one clock, so no pointer synchroniser is needed.
- Adds the following over the dual-clock FIFO:
  - selectable first-word-fall-through (FWFT) read mode
  - a fill-level output
  - programmable almost-full / almost-empty flags
  - sticky overflow / underflow error flags

Parameters:
- DSIZE, 8, data width in bits.
- ASIZE, 4, address width; DEPTH = 2**ASIZE entries.
- AFULL_TH, 12, walmost_full asserts when level >= AFULL_TH (legal range 1..DEPTH).
- AEMPTY_TH, 4, ralmost_empty asserts when level <= AEMPTY_TH (legal range 0..DEPTH-1).
- FWFT, 0, 0 = standard registered read; 1 = head word shown on rdata while rempty is low.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- wdata  in  DSIZE  write data.
- winc  in  1  write request.
- wfull  out  1  FIFO holds DEPTH entries.
- walmost_full  out  1  level >= AFULL_TH.
- rinc  in  1  read (pop) request.
- rdata  out  DSIZE  read data.
- rempty  out  1  FIFO holds 0 entries.
- ralmost_empty  out  1  level <= AEMPTY_TH.
- level  out  ASIZE+1  current entry count, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst_n low at a clk edge): pointers = 0, level = 0, rempty = 1, wfull = 0, ralmost_empty = 1, walmost_full = 0 (unless AFULL_TH = 0, which is illegal), overflow = 0, underflow = 0, rdata = 0. Memory contents are not reset. Reset asserted mid-traffic discards all contents on that edge; winc/rinc in that cycle are ignored.
- Pointers: write and read pointers are ASIZE+1-bit binary. Address = low ASIZE bits; the MSB distinguishes full from empty. Pointers wrap modulo 2**(ASIZE+1) with no special casing.
- pop = rinc && !rempty.
- push = winc && (!wfull || pop): a write while full is accepted only if a pop occurs in the same cycle.
- level_next = level + push - pop. Therefore:
  - simultaneous push and pop leaves level unchanged;
  - when empty, a simultaneous rinc is rejected and winc is accepted, so level becomes 1.
- Flags: wfull, rempty, walmost_full, ralmost_empty and level are registered, computed from level_next, and valid the cycle after the causing edge. No combinational path from winc/rinc to any flag.
- Errors:
  - overflow sets on winc && wfull && !pop.
  - underflow sets on rinc && rempty.
  - Both are sticky until reset. A rejected operation never moves a pointer or corrupts memory.
- Write: on push, mem[waddr] <= wdata and the write pointer increments.
- Read, FWFT = 0:
  - On pop, rdata <= mem[raddr] at that edge, so data is visible one cycle after rinc.
  - rdata holds its value when there is no pop.
  - An underflow read leaves rdata unchanged.
- Read, FWFT = 1:
  - rdata = mem[raddr] (head word), valid whenever rempty = 0.
  - A pop advances to the next word, visible the following cycle.
  - A write into an empty FIFO: rempty falls and the word appears on rdata the cycle after the write edge.
  - rdata is don't-care while rempty = 1.
- Read-during-write to the same address (only possible with level = 0 or DEPTH and both operations accepted) returns the old, correctly ordered data. No bypass is needed because pop requires level > 0.

Test Plan:
- Reset, then 16 writes of 0x00..0x0F with no reads (defaults) -> level counts 1..16; walmost_full rises the cycle after the 12th write; wfull = 1 after the 16th. A 17th winc -> overflow = 1, level stays 16, memory unchanged.
- From full, 16 reads, FWFT = 0 -> rdata = 0x00..0x0F, each one cycle after its rinc; ralmost_empty = 1 once level <= 4; rempty = 1 after the last read. A further rinc -> underflow = 1, rdata holds 0x0F.
- Continuous simultaneous winc/rinc at level 8 for 40 cycles with an incrementing pattern -> level stays 8, data order preserved across pointer wrap (>2 wraps), no error flags.
- When full, winc and rinc in the same cycle -> write accepted, level stays 16, overflow stays 0. When empty, winc and rinc together -> level = 1, underflow = 1.
- FWFT = 1: write 0xA5 into an empty FIFO -> next cycle rempty = 0 and rdata = 0xA5 with no rinc. Write 0x3C, then pop -> rdata = 0x3C the next cycle.
- Assert rst_n low mid-stream at level 7 with overflow set -> next cycle level = 0, rempty = 1, overflow = 0. A winc in the reset cycle is ignored.

Source files
------------

// File: rtl/sync_fifo_lvl_if.sv
// Handshake bundle for sync_fifo_lvl: write side, read side, status and sticky errors.
interface sync_fifo_lvl_if #(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
);
   logic [DSIZE-1:0] wdata;
   logic             winc;
   logic             wfull;
   logic             walmost_full;
   logic             rinc;
   logic [DSIZE-1:0] rdata;
   logic             rempty;
   logic             ralmost_empty;
   logic [ASIZE:0]   level;
   logic             overflow;
   logic             underflow;

   modport master (
      output wdata, winc, rinc,
      input  wfull, walmost_full, rdata, rempty, ralmost_empty, level, overflow, underflow
   );

   modport slave (
      input  wdata, winc, rinc,
      output wfull, walmost_full, rdata, rempty, ralmost_empty, level, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with fill level, programmable almost flags, sticky errors and
// optional first-word-fall-through read.
module sync_fifo_lvl #(
   parameter int DSIZE     = 8,
   parameter int ASIZE     = 4,
   parameter int AFULL_TH  = 12,
   parameter int AEMPTY_TH = 4,
   parameter int FWFT      = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   sync_fifo_lvl_if.slave fifo
);
   localparam int DEPTH = 1 << ASIZE;

   logic [DSIZE-1:0] mem [DEPTH];
   logic [ASIZE:0]   wptr;
   logic [ASIZE:0]   rptr;
   logic [ASIZE:0]   level_q;
   logic [ASIZE:0]   level_nxt;
   logic             wfull_q;
   logic             rempty_q;
   logic             walmost_full_q;
   logic             ralmost_empty_q;
   logic             overflow_q;
   logic             underflow_q;
   logic             push;
   logic             pop;

   // A write while full is only taken when a pop frees a slot on the same edge.
   always_comb begin
      pop       = fifo.rinc && !rempty_q;
      push      = fifo.winc && (!wfull_q || pop);
      level_nxt = level_q + (ASIZE+1)'(push) - (ASIZE+1)'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr            <= '0;
         rptr            <= '0;
         level_q         <= '0;
         wfull_q         <= 1'b0;
         rempty_q        <= 1'b1;
         walmost_full_q  <= 1'b0;
         ralmost_empty_q <= 1'b1;
         overflow_q      <= 1'b0;
         underflow_q     <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         level_q         <= level_nxt;
         wfull_q         <= (level_nxt == (ASIZE+1)'(DEPTH));
         rempty_q        <= (level_nxt == '0);
         walmost_full_q  <= (level_nxt >= (ASIZE+1)'(AFULL_TH));
         ralmost_empty_q <= (level_nxt <= (ASIZE+1)'(AEMPTY_TH));
         if (fifo.winc && wfull_q && !pop) overflow_q  <= 1'b1;
         if (fifo.rinc && rempty_q)        underflow_q <= 1'b1;
      end
   end

   // Storage is not reset; rst_n only blocks the write on the reset edge.
   always_ff @(posedge clk) begin
      if (rst_n && push) mem[wptr[ASIZE-1:0]] <= fifo.wdata;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign fifo.rdata = mem[rptr[ASIZE-1:0]];
      end else begin : g_std
         logic [DSIZE-1:0] rdata_q;
         always_ff @(posedge clk) begin
            if (!rst_n)   rdata_q <= '0;
            else if (pop) rdata_q <= mem[rptr[ASIZE-1:0]];
         end
         assign fifo.rdata = rdata_q;
      end
   endgenerate

   assign fifo.wfull         = wfull_q;
   assign fifo.rempty        = rempty_q;
   assign fifo.walmost_full  = walmost_full_q;
   assign fifo.ralmost_empty = ralmost_empty_q;
   assign fifo.level         = level_q;
   assign fifo.overflow      = overflow_q;
   assign fifo.underflow     = underflow_q;
endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed bench for sync_fifo_lvl: standard-read instance u0 and FWFT instance u1.
module tb_sync_fifo_lvl;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   sync_fifo_lvl_if #(.DSIZE(8), .ASIZE(4)) b0 ();
   sync_fifo_lvl_if #(.DSIZE(8), .ASIZE(4)) b1 ();

   sync_fifo_lvl #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .fifo(b0.slave));
   sync_fifo_lvl #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .fifo(b1.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0;
      b0.winc = 1'b0; b0.rinc = 1'b0; b0.wdata = '0;
      b1.winc = 1'b0; b1.rinc = 1'b0; b1.wdata = '0;
      tick(); tick();
      rst_n = 1'b1;

      chk("rst_level", 32'(b0.level), 0);
      chk("rst_rempty", 32'(b0.rempty), 1);
      chk("rst_wfull", 32'(b0.wfull), 0);
      chk("rst_aempty", 32'(b0.ralmost_empty), 1);
      chk("rst_afull", 32'(b0.walmost_full), 0);
      chk("rst_ovf", 32'(b0.overflow), 0);
      chk("rst_unf", 32'(b0.underflow), 0);
      chk("rst_rdata", 32'(b0.rdata), 0);

      // fill 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         b0.winc = 1'b1; b0.wdata = 8'(i);
         tick();
         chk("fill_level", 32'(b0.level), 32'(i + 1));
         chk("fill_afull", 32'(b0.walmost_full), 32'((i + 1) >= 12));
         chk("fill_wfull", 32'(b0.wfull), 32'((i + 1) == 16));
         chk("fill_aempty", 32'(b0.ralmost_empty), 32'((i + 1) <= 4));
         chk("fill_rempty", 32'(b0.rempty), 0);
      end
      b0.wdata = 8'hEE;
      tick();
      b0.winc = 1'b0;
      chk("ovf_flag", 32'(b0.overflow), 1);
      chk("ovf_level", 32'(b0.level), 16);
      chk("ovf_wfull", 32'(b0.wfull), 1);

      // drain, standard read
      for (int i = 0; i < 16; i++) begin
         b0.rinc = 1'b1;
         tick();
         chk("drain_rdata", 32'(b0.rdata), 32'(i));
         chk("drain_level", 32'(b0.level), 32'(15 - i));
         chk("drain_aempty", 32'(b0.ralmost_empty), 32'((15 - i) <= 4));
         chk("drain_rempty", 32'(b0.rempty), 32'(i == 15));
         chk("drain_wfull", 32'(b0.wfull), 0);
      end
      tick();
      b0.rinc = 1'b0;
      chk("unf_flag", 32'(b0.underflow), 1);
      chk("unf_rdata", 32'(b0.rdata), 32'h0F);
      chk("unf_level", 32'(b0.level), 0);

      // empty: simultaneous winc/rinc
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk("rst2_unf", 32'(b0.underflow), 0);
      b0.winc = 1'b1; b0.rinc = 1'b1; b0.wdata = 8'h55;
      tick();
      b0.winc = 1'b0;
      chk("ew_level", 32'(b0.level), 1);
      chk("ew_unf", 32'(b0.underflow), 1);
      chk("ew_rempty", 32'(b0.rempty), 0);
      tick();
      b0.rinc = 1'b0;
      chk("ew_rdata", 32'(b0.rdata), 32'h55);
      chk("ew_level0", 32'(b0.level), 0);

      // streaming at level 8 across pointer wraps
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b0.winc = 1'b1; b0.wdata = 8'(i);
         tick();
      end
      chk("st_pre_level", 32'(b0.level), 8);
      for (int c = 0; c < 40; c++) begin
         b0.winc = 1'b1; b0.rinc = 1'b1; b0.wdata = 8'(8 + c);
         tick();
         chk("st_rdata", 32'(b0.rdata), 32'(c));
         chk("st_level", 32'(b0.level), 8);
      end
      b0.winc = 1'b0;
      for (int j = 0; j < 8; j++) begin
         tick();
         chk("st_drain", 32'(b0.rdata), 32'(40 + j));
         chk("st_dlevel", 32'(b0.level), 32'(7 - j));
      end
      b0.rinc = 1'b0;
      chk("st_ovf", 32'(b0.overflow), 0);
      chk("st_unf", 32'(b0.underflow), 0);

      // full: simultaneous winc/rinc
      for (int i = 0; i < 16; i++) begin
         b0.winc = 1'b1; b0.wdata = 8'(8'h80 + i);
         tick();
      end
      chk("fw_pre_full", 32'(b0.wfull), 1);
      b0.rinc = 1'b1; b0.wdata = 8'h99;
      tick();
      b0.winc = 1'b0;
      chk("fw_level", 32'(b0.level), 16);
      chk("fw_ovf", 32'(b0.overflow), 0);
      chk("fw_rdata", 32'(b0.rdata), 32'h80);
      chk("fw_wfull", 32'(b0.wfull), 1);
      for (int i = 1; i < 16; i++) begin
         tick();
         chk("fw_drain", 32'(b0.rdata), 32'(8'h80 + i));
      end
      tick();
      b0.rinc = 1'b0;
      chk("fw_last", 32'(b0.rdata), 32'h99);
      chk("fw_empty", 32'(b0.rempty), 1);

      // mid-stream reset at level 7 with overflow set
      for (int i = 0; i < 17; i++) begin
         b0.winc = 1'b1; b0.wdata = 8'(i);
         tick();
      end
      b0.winc = 1'b0;
      chk("mr_ovf_set", 32'(b0.overflow), 1);
      b0.rinc = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      b0.rinc = 1'b0;
      chk("mr_level7", 32'(b0.level), 7);
      rst_n = 1'b0; b0.winc = 1'b1; b0.wdata = 8'h77;
      tick();
      rst_n = 1'b1; b0.winc = 1'b0;
      chk("mr_level", 32'(b0.level), 0);
      chk("mr_rempty", 32'(b0.rempty), 1);
      chk("mr_ovf", 32'(b0.overflow), 0);
      tick();
      chk("mr_winc_ign", 32'(b0.level), 0);

      // FWFT instance
      chk("fwft_empty", 32'(b1.rempty), 1);
      b1.winc = 1'b1; b1.wdata = 8'hA5;
      tick();
      b1.winc = 1'b0;
      chk("fwft_rempty", 32'(b1.rempty), 0);
      chk("fwft_head", 32'(b1.rdata), 32'hA5);
      chk("fwft_level1", 32'(b1.level), 1);
      b1.winc = 1'b1; b1.wdata = 8'h3C;
      tick();
      b1.winc = 1'b0;
      chk("fwft_hold", 32'(b1.rdata), 32'hA5);
      chk("fwft_level2", 32'(b1.level), 2);
      b1.rinc = 1'b1;
      tick();
      b1.rinc = 1'b0;
      chk("fwft_pop", 32'(b1.rdata), 32'h3C);
      chk("fwft_level3", 32'(b1.level), 1);
      chk("fwft_unf", 32'(b1.underflow), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
